// File: rtl/alu_result_serializer.sv
// ALU result serializer: captures a WIDTH-bit result and
// streams it out LSB-first as bytes over valid/ready.
module alu_result_serializer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_valid,
   input  logic             tx_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   output logic             busy,
   output logic             overrun
);

   localparam int BYTES = WIDTH / 8;
   localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t                  state_q, state_d;
   logic [BYTES-1:0][7:0]   shadow_q, shadow_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [7:0]              tx_data_q, tx_data_d;
   logic                    tx_valid_q, busy_q;
   logic                    overrun_q, overrun_d;
   logic                    xfer, last;

   assign xfer = tx_valid_q & tx_ready;
   assign last = (idx_q == IW'(BYTES - 1));

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      idx_d     = idx_q;
      overrun_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (alu_valid) begin
               shadow_d = alu_result;
               idx_d    = '0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (xfer && !last) begin
               idx_d = idx_q + IW'(1);
            end else if (xfer && last) begin
               if (alu_valid) begin
                  shadow_d = alu_result;
                  idx_d    = '0;
               end else begin
                  state_d = IDLE;
               end
            end
            // a result offered outside a last-byte transfer is dropped
            if (alu_valid && !(xfer && last)) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      tx_data_d = (state_d == SEND) ? shadow_d[idx_d] : tx_data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         idx_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= (state_d == SEND);
         busy_q     <= (state_d == SEND);
         overrun_q  <= overrun_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed vector table,
// reset/32-bit sequences and a queue-based random model.
module tb_alu_result_serializer;

   logic        clk;
   logic        rst;
   logic [15:0] ar;
   logic        av, rdy;
   logic [7:0]  td;
   logic        tv, bz, ov;

   logic [31:0] ar32;
   logic        av32, rdy32;
   logic [7:0]  td32;
   logic        tv32, bz32, ov32;

   int total, passed;

   logic [7:0] q[$];
   logic       ovr_m;

   typedef struct {
      logic        av;
      logic [15:0] ar;
      logic        rdy;
      logic        ev;
      logic [7:0]  ed;
      logic        eo;
   } vec_t;

   vec_t vecs[$];

   alu_result_serializer #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .alu_result(ar), .alu_valid(av),
      .tx_ready(rdy), .tx_data(td), .tx_valid(tv),
      .busy(bz), .overrun(ov)
   );

   alu_result_serializer #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .alu_result(ar32), .alu_valid(av32),
      .tx_ready(rdy32), .tx_data(td32), .tx_valid(tv32),
      .busy(bz32), .overrun(ov32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_check();
      chk("m_valid", {31'd0, tv}, {31'd0, q.size() > 0});
      chk("m_busy", {31'd0, bz}, {31'd0, q.size() > 0});
      chk("m_ovr", {31'd0, ov}, {31'd0, ovr_m});
      if (q.size() > 0) chk("m_data", {24'd0, td}, {24'd0, q[0]});
   endtask

   // one clock: drive at negedge, update model at posedge, check at negedge
   task automatic cyc(input logic a, input logic [15:0] r,
                      input logic y);
      logic was_v, x;
      av  = a;
      ar  = r;
      rdy = y;
      @(posedge clk);
      was_v = q.size() > 0;
      x     = was_v && y;
      if (x) void'(q.pop_front());
      ovr_m = 1'b0;
      if (a) begin
         if (!was_v || (x && q.size() == 0)) begin
            q.push_back(r[7:0]);
            q.push_back(r[15:8]);
         end else begin
            ovr_m = 1'b1;
         end
      end
      @(negedge clk);
      model_check();
   endtask

   task automatic v(input logic a, input logic [15:0] r, input logic y,
                    input logic ev, input logic [7:0] ed,
                    input logic eo);
      vec_t t;
      t.av = a; t.ar = r; t.rdy = y; t.ev = ev; t.ed = ed; t.eo = eo;
      vecs.push_back(t);
   endtask

   initial begin
      int busy_cnt;
      logic [7:0] exp32[4];
      total = 0;
      passed = 0;
      ovr_m = 1'b0;
      rst = 1'b0;
      av = 0; ar = '0; rdy = 0;
      av32 = 0; ar32 = '0; rdy32 = 0;

      // basic frame A55A
      v(1, 16'hA55A, 1, 1, 8'h5A, 0);
      v(0, 16'h0000, 1, 1, 8'hA5, 0);
      v(0, 16'h0000, 1, 0, 8'h00, 0);
      // backpressure 1234
      v(1, 16'h1234, 0, 1, 8'h34, 0);
      for (int i = 0; i < 4; i++) v(0, 16'h0000, 0, 1, 8'h34, 0);
      v(0, 16'h0000, 1, 1, 8'h12, 0);
      v(0, 16'h0000, 1, 0, 8'h00, 0);
      v(0, 16'h0000, 1, 0, 8'h00, 0);
      // back-to-back 00FF then BEEF on last-byte transfer
      v(1, 16'h00FF, 1, 1, 8'hFF, 0);
      v(0, 16'h0000, 1, 1, 8'h00, 0);
      v(1, 16'hBEEF, 1, 1, 8'hEF, 0);
      v(0, 16'h0000, 1, 1, 8'hBE, 0);
      v(0, 16'h0000, 1, 0, 8'h00, 0);
      // overrun while CAFE is held
      v(1, 16'hCAFE, 0, 1, 8'hFE, 0);
      v(1, 16'h1111, 0, 1, 8'hFE, 1);
      v(0, 16'h0000, 0, 1, 8'hFE, 0);
      v(1, 16'h1111, 0, 1, 8'hFE, 1);
      v(0, 16'h0000, 1, 1, 8'hCA, 0);
      v(0, 16'h0000, 1, 0, 8'h00, 0);

      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, tv}, 0);
      chk("rst_busy", {31'd0, bz}, 0);
      chk("rst_data", {24'd0, td}, 0);
      chk("rst_ovr", {31'd0, ov}, 0);
      rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         cyc(vecs[i].av, vecs[i].ar, vecs[i].rdy);
         chk($sformatf("vec%0d_valid", i), {31'd0, tv},
             {31'd0, vecs[i].ev});
         chk($sformatf("vec%0d_busy", i), {31'd0, bz},
             {31'd0, vecs[i].ev});
         chk($sformatf("vec%0d_ovr", i), {31'd0, ov},
             {31'd0, vecs[i].eo});
         if (vecs[i].ev)
            chk($sformatf("vec%0d_data", i), {24'd0, td},
                {24'd0, vecs[i].ed});
      end

      // reset mid-frame after byte0 has gone
      cyc(1, 16'hA55A, 1);
      cyc(0, 16'h0000, 1);
      chk("mid_pre_data", {24'd0, td}, 32'hA5);
      rst = 1'b0;
      #1;
      q.delete();
      ovr_m = 1'b0;
      chk("mid_valid", {31'd0, tv}, 0);
      chk("mid_busy", {31'd0, bz}, 0);
      chk("mid_data", {24'd0, td}, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 16'h0000, 1);
         chk("mid_no_byte", {31'd0, tv}, 0);
      end

      // 32-bit instance
      exp32[0] = 8'hEF; exp32[1] = 8'hCD;
      exp32[2] = 8'hAB; exp32[3] = 8'h89;
      busy_cnt = 0;
      av32 = 1; ar32 = 32'h89AB_CDEF; rdy32 = 1;
      @(posedge clk);
      @(negedge clk);
      av32 = 0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("w32_valid%0d", i), {31'd0, tv32}, 1);
         chk($sformatf("w32_data%0d", i), {24'd0, td32},
             {24'd0, exp32[i]});
         if (bz32) busy_cnt++;
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         if (bz32) busy_cnt++;
         @(negedge clk);
      end
      chk("w32_busy_cycles", busy_cnt, 4);
      chk("w32_idle", {31'd0, tv32}, 0);

      // random against the queue model
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 2) == 0, 16'($urandom),
             $urandom_range(0, 1) == 1);
      end
      for (int i = 0; i < 4; i++) cyc(0, 16'h0000, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Consumer end of the ALU result interface. Captures each WIDTH-bit result that an ALU execution unit presents with its valid flag.
- Serializes the captured result into bytes, LSB first, toward the UART transmit path over a valid/ready handshake.
- Sits between the ALU output mux and the UART TX data FIFO. Reports busy so the system controller can hold off issuing new ALU operations.

Parameters:
- WIDTH, 16, ALU result width in bits; must be a non-zero multiple of 8.
- BYTES, WIDTH/8, derived; number of bytes per result. Not overridden independently.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset
- alu_result  input  WIDTH  ALU result; sampled only when alu_valid=1 and the result is accepted
- alu_valid  input  1  result-valid flag from the ALU side; level, one result per high cycle
- tx_ready  input  1  downstream (TX FIFO) can accept a byte this cycle
- tx_data  output  8  current byte
- tx_valid  output  1  tx_data holds a valid byte
- busy  output  1  result held and not yet fully transmitted
- overrun  output  1  one-cycle pulse: an offered result was dropped

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, shadow register=0, byte index=0, tx_data=0, tx_valid=0, busy=0, overrun=0. Any in-flight result is discarded; no partial byte is emitted after reset release.
- Storage: one WIDTH-bit shadow register and a byte index counter of width max(1, clog2(BYTES)).
- FSM state IDLE:
  - tx_valid=0, busy=0.
  - On a rising edge with alu_valid=1: load shadow<=alu_result, index<=0, go to SEND.
- FSM state SEND:
  - tx_valid=1, busy=1, tx_data=shadow[8*index+7 : 8*index].
  - Transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - Transfer, index<BYTES-1: index<=index+1; stay in SEND.
  - Transfer, index=BYTES-1 (last byte), alu_valid=0: go to IDLE.
  - Transfer on last byte, alu_valid=1 in the same cycle: load the new result, index<=0, stay in SEND. This is not an overrun; tx_valid stays high with no bubble.
- Latency: alu_valid high in cycle N → tx_valid=1 with byte0 in cycle N+1. Minimum BYTES cycles per result when tx_ready is held high.
- Stability: while tx_valid=1 and tx_ready=0, tx_data and the shadow register hold unchanged (backpressure of any length).
- Overrun: in SEND, alu_valid=1 in any cycle that is not a last-byte transfer → the offered result is ignored, the shadow is unchanged, and overrun=1 for exactly the next cycle. Each such cycle produces its own pulse.
- tx_data is registered. It is driven from the shadow/index registers only, with no combinational path from alu_result or tx_ready.
- tx_ready is ignored in IDLE.
- busy = (state==SEND); it is registered-state derived and glitch-free.
- Outputs are functions of registered state only (Moore-style); overrun is a registered pulse.

Test Plan:
- Reset mid-frame: WIDTH=16, tx_ready=1. Apply rst=0, then release. Drive alu_result=0xA55A with alu_valid for 1 cycle → next cycle tx_valid=1, tx_data=0x5A; following cycle tx_data=0xA5; then tx_valid=0, busy=0. Separately, assert rst=0 mid-frame, after byte0 transfers → tx_valid, busy and tx_data=0 immediately; no byte 0xA5 appears after release.
- Backpressure: load 0x1234 with tx_ready=0 for 5 cycles → tx_valid=1, tx_data=0x34 held for all 5 cycles. Raise tx_ready → 0x34 then 0x12 transferred, each exactly once.
- Back-to-back: load 0x00FF; assert alu_valid with 0xBEEF on the cycle the last byte (0x00) transfers → overrun stays 0; byte sequence is 0xFF, 0x00, 0xEF, 0xBE with tx_valid continuously high.
- Overrun: load 0xCAFE with tx_ready=0; pulse alu_valid with 0x1111 twice on non-consecutive cycles → two single-cycle overrun pulses; output bytes remain 0xFE, 0xCA.
- WIDTH=32: load 0x89ABCDEF with tx_ready=1 → bytes 0xEF, 0xCD, 0xAB, 0x89 on 4 consecutive cycles; busy high for exactly 4 cycles.
